// File: rtl/vec_wb_arbiter.sv
// Write-back arbiter for the single write port of vector_reg_file.
// MEM normally wins; a saturating wait counter forces an ALU grant after starveLimit lost cycles.
module vec_wb_arbiter #(
  parameter int unsigned regSize     = 8,
  parameter int unsigned regQuantity = 4,
  parameter int unsigned selBits     = 2,
  parameter int unsigned vecSize     = 4,
  parameter int unsigned starveLimit = 3,
  parameter int unsigned cntBits     = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wbStall,
  input  logic                            aluValid,
  input  logic [selBits-1:0]              aluReg,
  input  logic [vecSize-1:0][regSize-1:0] aluData,
  output logic                            aluReady,
  input  logic                            memValid,
  input  logic [selBits-1:0]              memReg,
  input  logic [vecSize-1:0][regSize-1:0] memData,
  output logic                            memReady,
  output logic                            regWrEn,
  output logic [selBits-1:0]              regToWrite,
  output logic [vecSize-1:0][regSize-1:0] regWriteData
);

  // Reject configurations the counter or the select field cannot represent.
  if (starveLimit < 1 || starveLimit > (1 << cntBits) - 1) begin : g_bad_starve
    $error("vec_wb_arbiter: starveLimit must be in 1..2**cntBits-1");
  end
  if (regQuantity > (1 << selBits)) begin : g_bad_sel
    $error("vec_wb_arbiter: selBits too narrow for regQuantity");
  end

  localparam logic [cntBits-1:0] StarveMax = cntBits'(starveLimit);

  logic                            alu_gnt;
  logic                            mem_gnt;
  logic [cntBits-1:0]              wait_cnt_q;
  logic [cntBits-1:0]              wait_cnt_d;
  logic                            wr_en_q;
  logic [selBits-1:0]              wr_reg_q;
  logic [vecSize-1:0][regSize-1:0] wr_data_q;

  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (!reset && !wbStall) begin
      if (aluValid && (wait_cnt_q == StarveMax)) begin
        alu_gnt = 1'b1;
      end else if (memValid) begin
        mem_gnt = 1'b1;
      end else if (aluValid) begin
        alu_gnt = 1'b1;
      end
    end
  end

  assign aluReady = alu_gnt;
  assign memReady = mem_gnt;

  // A stall freezes the counter even if the ALU drops its request.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!wbStall) begin
      if (!aluValid || alu_gnt) begin
        wait_cnt_d = '0;
      end else if (mem_gnt && (wait_cnt_q != StarveMax)) begin
        wait_cnt_d = wait_cnt_q + cntBits'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q    <= 1'b0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      wr_en_q    <= alu_gnt | mem_gnt;
      wait_cnt_q <= wait_cnt_d;
      if (alu_gnt) begin
        wr_reg_q  <= aluReg;
        wr_data_q <= aluData;
      end else if (mem_gnt) begin
        wr_reg_q  <= memReg;
        wr_data_q <= memData;
      end
    end
  end

  assign regWrEn      = wr_en_q;
  assign regToWrite   = wr_reg_q;
  assign regWriteData = wr_data_q;

endmodule

// File: tb/tb_vec_wb_arbiter.sv
// Directed bench for vec_wb_arbiter with a small behavioural register file on the write port.
module tb_vec_wb_arbiter;

  logic                clk = 1'b0;
  logic                reset;
  logic                wbStall;
  logic                aluValid;
  logic [1:0]          aluReg;
  logic [3:0][7:0]     aluData;
  logic                aluReady;
  logic                memValid;
  logic [1:0]          memReg;
  logic [3:0][7:0]     memData;
  logic                memReady;
  logic                regWrEn;
  logic [1:0]          regToWrite;
  logic [3:0][7:0]     regWriteData;

  logic [3:0][7:0]     rf [4];

  int checks = 0;
  int errors = 0;

  vec_wb_arbiter #(
    .regSize     (8),
    .regQuantity (4),
    .selBits     (2),
    .vecSize     (4),
    .starveLimit (3),
    .cntBits     (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wbStall      (wbStall),
    .aluValid     (aluValid),
    .aluReg       (aluReg),
    .aluData      (aluData),
    .aluReady     (aluReady),
    .memValid     (memValid),
    .memReg       (memReg),
    .memData      (memData),
    .memReady     (memReady),
    .regWrEn      (regWrEn),
    .regToWrite   (regToWrite),
    .regWriteData (regWriteData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (regWrEn) rf[regToWrite] <= regWriteData;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance into the next cycle; inputs are driven just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic exp_mem [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [1:0] exp_cnt [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] exp_reg [5] = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd1};

  initial begin
    reset = 1'b1; wbStall = 1'b0;
    aluValid = 1'b0; aluReg = '0; aluData = '0;
    memValid = 1'b0; memReg = '0; memData = '0;

    // Reset with both requesters valid
    cyc();
    aluValid = 1'b1; memValid = 1'b1; aluReg = 2'd2; memReg = 2'd3;
    aluData = 32'h01020304; memData = 32'h05060708;
    @(negedge clk);
    check("rst_alu_ready", aluReady, 1'b0);
    check("rst_mem_ready", memReady, 1'b0);
    cyc();
    @(negedge clk);
    check("rst_wr_en", regWrEn, 1'b0);
    check("rst_reg", regToWrite, 2'd0);
    check("rst_data", regWriteData, 32'h0);
    check("rst_cnt", dut.wait_cnt_q, 2'd0);

    // Single ALU write
    cyc();
    reset = 1'b0; memValid = 1'b0;
    aluValid = 1'b1; aluReg = 2'd1; aluData = 32'hDEADBEEF;
    @(negedge clk);
    check("alu_ready", aluReady, 1'b1);
    check("alu_mem_ready", memReady, 1'b0);
    cyc();
    aluValid = 1'b0;
    @(negedge clk);
    check("alu_wr_en", regWrEn, 1'b1);
    check("alu_reg", regToWrite, 2'd1);
    check("alu_msb", regWriteData[3], 8'hDE);
    check("alu_lsb", regWriteData[0], 8'hEF);
    cyc();
    @(negedge clk);
    check("alu_wr_en_off", regWrEn, 1'b0);
    check("alu_rf1", rf[1], 32'hDEADBEEF);

    // Starvation bound: MEM wins 0-2, ALU forced at 3, MEM again at 4
    cyc();
    memValid = 1'b1; memReg = 2'd3; memData = 32'h1A2B3C4D;
    aluValid = 1'b1; aluReg = 2'd1; aluData = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stv_mem_ready_%0d", i), memReady, exp_mem[i]);
      check($sformatf("stv_alu_ready_%0d", i), aluReady, !exp_mem[i]);
      check($sformatf("stv_cnt_%0d", i), dut.wait_cnt_q, exp_cnt[i]);
      if (i > 0) check($sformatf("stv_reg_%0d", i), regToWrite, exp_reg[i]);
      cyc();
    end
    @(negedge clk);
    check("stv_reg_5", regToWrite, 2'd3);

    // Stall: ALU held off, counter frozen at 0
    memValid = 1'b0; aluValid = 1'b0;
    cyc();
    wbStall = 1'b1; aluValid = 1'b1; aluReg = 2'd0; aluData = 32'h55AA33CC;
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      check($sformatf("stall_ready_%0d", i), aluReady, 1'b0);
      check($sformatf("stall_wr_en_%0d", i), regWrEn, 1'b0);
      check($sformatf("stall_cnt_%0d", i), dut.wait_cnt_q, 2'd0);
    end
    cyc();
    wbStall = 1'b0;
    @(negedge clk);
    check("unstall_ready", aluReady, 1'b1);
    check("unstall_wr_en0", regWrEn, 1'b0);
    cyc();
    aluValid = 1'b0;
    @(negedge clk);
    check("unstall_wr_en1", regWrEn, 1'b1);
    check("unstall_data", regWriteData, 32'h55AA33CC);

    // Same-register collision
    cyc();
    memValid = 1'b1; memReg = 2'd2; memData = 32'h11111111;
    aluValid = 1'b1; aluReg = 2'd2; aluData = 32'h22222222;
    @(negedge clk);
    check("col_mem_ready", memReady, 1'b1);
    check("col_alu_ready0", aluReady, 1'b0);
    cyc();
    memValid = 1'b0;
    @(negedge clk);
    check("col_alu_ready1", aluReady, 1'b1);
    check("col_wr1_data", regWriteData, 32'h11111111);
    cyc();
    aluValid = 1'b0;
    @(negedge clk);
    check("col_wr2_en", regWrEn, 1'b1);
    check("col_wr2_data", regWriteData, 32'h22222222);
    cyc();
    cyc();
    @(negedge clk);
    check("col_rf2", rf[2], 32'h22222222);

    // Reset mid-stream
    cyc();
    memValid = 1'b1; memReg = 2'd3; memData = 32'hAABBCCDD;
    aluValid = 1'b1; aluReg = 2'd1; aluData = 32'h99887766;
    @(negedge clk);
    check("mid_mem_ready", memReady, 1'b1);
    cyc();
    reset = 1'b1; memValid = 1'b0;
    @(negedge clk);
    check("mid_alu_ready", aluReady, 1'b0);
    check("mid_wr_en", regWrEn, 1'b1);
    check("mid_reg", regToWrite, 2'd3);
    check("mid_cnt", dut.wait_cnt_q, 2'd1);
    cyc();
    reset = 1'b0; aluValid = 1'b0;
    @(negedge clk);
    check("post_wr_en", regWrEn, 1'b0);
    check("post_reg", regToWrite, 2'd0);
    check("post_data", regWriteData, 32'h0);
    check("post_cnt", dut.wait_cnt_q, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
